// File: rtl/apb_pkg.sv
// Shared definitions for the APB register-file completer.
// Holds the FSM state encoding, the bus widths and the byte-lane merge helper
// that the top module uses to commit strobed writes.
package apb_pkg;

   localparam int unsigned APB_DW = 32;  // data / address width
   localparam int unsigned APB_SW = 4;   // strobe width (one bit per byte)
   localparam int unsigned IDX_W  = 4;   // register index width (up to 16 registers)

   typedef enum logic {
      StIdle   = 1'b0,
      StAccess = 1'b1
   } apb_state_e;

   // Replace only the byte lanes whose strobe bit is set.
   function automatic logic [APB_DW-1:0] merge_bytes(input logic [APB_DW-1:0] old_word,
                                                     input logic [APB_DW-1:0] new_word,
                                                     input logic [APB_SW-1:0] strb);
      logic [APB_DW-1:0] merged;
      merged = old_word;
      for (int k = 0; k < int'(APB_SW); k++) begin
         if (strb[k]) merged[8*k +: 8] = new_word[8*k +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/apb_regfile_slave_if.sv
// APB bus bundle between a requester and the register-file completer.
// Request signals: PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT.
// Response signals: PREADY, PRDATA, PSLVERR.
interface apb_regfile_slave_if;

   logic                         PSEL;
   logic                         PENABLE;
   logic                         PWRITE;
   logic [apb_pkg::APB_DW-1:0]   PADDR;
   logic [apb_pkg::APB_DW-1:0]   PWDATA;
   logic [apb_pkg::APB_SW-1:0]   PSTRB;
   logic [2:0]                   PPROT;
   logic                         PREADY;
   logic [apb_pkg::APB_DW-1:0]   PRDATA;
   logic                         PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
      input  PREADY, PRDATA, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
      output PREADY, PRDATA, PSLVERR
   );

endinterface

// File: rtl/apb_addr_decode.sv
// Combinational address decoder for the APB register file.
// paddr_i  : byte address presented in the setup phase
// pwrite_i : transfer direction (1 = write)
// idx_o    : register index (PADDR - BASE_ADDR) >> 2, low IDX_W bits
// err_o    : misaligned, out of range (including underflow) or write to a read-only slot
module apb_addr_decode
   import apb_pkg::*;
#(
   parameter int unsigned NUM_REGS  = 8,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [15:0] RO_MASK   = 16'h0000
) (
   input  logic [APB_DW-1:0] paddr_i,
   input  logic              pwrite_i,
   output logic [IDX_W-1:0]  idx_o,
   output logic              err_o
);

   logic [APB_DW-1:0] offset;
   logic [APB_DW-1:0] word;
   logic              misaligned;
   logic              out_of_range;
   logic              ro_write;

   always_comb begin
      offset       = paddr_i - BASE_ADDR;
      word         = offset >> 2;
      idx_o        = word[IDX_W-1:0];
      misaligned   = (paddr_i[1:0] != 2'b00);
      // Underflow wraps to a huge word index, but the explicit compare keeps it obvious.
      out_of_range = (paddr_i < BASE_ADDR) || (word >= NUM_REGS);
      ro_write     = pwrite_i && !out_of_range && RO_MASK[idx_o];
      err_o        = misaligned || out_of_range || ro_write;
   end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB completer holding NUM_REGS 32-bit registers behind one PSEL line.
// PCLK/PRESET : clock and synchronous active-high reset
// apb         : APB bus (slave modport)
// reg_out     : flat register contents, slot i = [32i+31:32i]
// hw_in       : live values returned for read-only (RO_MASK) slots
// wr_pulse    : one-cycle strobe the cycle after register i is written
module apb_regfile_slave
   import apb_pkg::*;
#(
   parameter int unsigned NUM_REGS    = 8,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 0,
   parameter logic [15:0] RO_MASK     = 16'h0000
) (
   input  logic                     PCLK,
   input  logic                     PRESET,
   apb_regfile_slave_if.slave       apb,
   output logic [NUM_REGS*32-1:0]   reg_out,
   input  logic [NUM_REGS*32-1:0]   hw_in,
   output logic [NUM_REGS-1:0]      wr_pulse
);

   localparam logic [3:0] WaitLoad = 4'(WAIT_STATES);

   apb_state_e          state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                write_q, write_d;
   logic                err_q, err_d;
   logic [APB_DW-1:0]   wdata_q, wdata_d;
   logic [APB_SW-1:0]   strb_q, strb_d;
   logic [APB_DW-1:0]   regs_q [NUM_REGS];
   logic [APB_DW-1:0]   regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

   logic [IDX_W-1:0]    dec_idx;
   logic                dec_err;
   logic                setup;
   logic                complete;
   logic                commit;
   logic [APB_DW-1:0]   rdata;
   logic                unused_pprot;

   assign unused_pprot = ^apb.PPROT;

   apb_addr_decode #(
      .NUM_REGS  (NUM_REGS),
      .BASE_ADDR (BASE_ADDR),
      .RO_MASK   (RO_MASK)
   ) u_decode (
      .paddr_i  (apb.PADDR),
      .pwrite_i (apb.PWRITE),
      .idx_o    (dec_idx),
      .err_o    (dec_err)
   );

   // FSM and setup-phase capture.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      write_d  = write_q;
      err_d    = err_q;
      wdata_d  = wdata_q;
      strb_d   = strb_q;
      setup    = (state_q == StIdle) && apb.PSEL && !apb.PENABLE;
      complete = (state_q == StAccess) && apb.PSEL && apb.PENABLE && (cnt_q == 4'd0);
      commit   = complete && write_q && !err_q;

      unique case (state_q)
         StIdle: begin
            // PSEL with PENABLE but no prior setup is ignored.
            if (setup) begin
               idx_d   = dec_idx;
               write_d = apb.PWRITE;
               err_d   = dec_err;
               wdata_d = apb.PWDATA;
               strb_d  = apb.PSTRB;
               cnt_d   = WaitLoad;
               state_d = StAccess;
            end
         end
         StAccess: begin
            if (!apb.PSEL) begin
               state_d = StIdle;
            end else if (apb.PENABLE) begin
               if (cnt_q == 4'd0) state_d = StIdle;
               else               cnt_d   = cnt_q - 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Register array update, read mux and bus outputs.
   always_comb begin
      wr_pulse_d = '0;
      rdata      = '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         regs_d[i] = regs_q[i];
         if (idx_q == IDX_W'(i)) begin
            rdata = RO_MASK[i] ? hw_in[32*i +: 32] : regs_q[i];
            if (commit) begin
               regs_d[i]     = merge_bytes(regs_q[i], wdata_q, strb_q);
               wr_pulse_d[i] = 1'b1;
            end
         end
         reg_out[32*i +: 32] = regs_q[i];
      end
      apb.PREADY  = complete;
      apb.PSLVERR = complete && err_q;
      apb.PRDATA  = (complete && !write_q && !err_q) ? rdata : '0;
      wr_pulse    = wr_pulse_q;
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         idx_q      <= '0;
         write_q    <= 1'b0;
         err_q      <= 1'b0;
         wdata_q    <= '0;
         strb_q     <= '0;
         wr_pulse_q <= '0;
         for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         write_q    <= write_d;
         err_q      <= err_d;
         wdata_q    <= wdata_d;
         strb_q     <= strb_d;
         wr_pulse_q <= wr_pulse_d;
         for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= regs_d[i];
      end
   end

endmodule
